// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: direction codes,
// Gray-code phase encodings and the forward-rotation helper.
package quad_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Phase is {A,B}; the up sequence is 00 -> 10 -> 11 -> 01 -> 00
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_10 = 2'b10,
        PH_11 = 2'b11
    } phase_t;

    function automatic phase_t next_up(input phase_t ph);
        phase_t nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Control/status bundle between the encoder front end and its user:
// phase inputs, enable and error clear in; step, direction and error out.
interface quad_step_decoder_if;

    logic i_en;
    logic i_a_in;
    logic i_b_in;
    logic i_err_clr;
    logic o_step;
    logic o_up_down;
    logic o_err;

    modport master (
        output i_en, i_a_in, i_b_in, i_err_clr,
        input  o_step, o_up_down, o_err
    );

    modport slave (
        input  i_en, i_a_in, i_b_in, i_err_clr,
        output o_step, o_up_down, o_err
    );

endinterface

// File: rtl/sync_glitch_filter.sv
// One encoder phase: metastability synchroniser followed by a persistence
// filter that only accepts a new level after it has held for FILT_LEN clocks.
module sync_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    input  logic i_load,
    input  logic i_run,
    output logic o_sync,
    output logic o_level,
    output logic o_qual
);

    localparam int FILT_W = $clog2(FILT_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILT_LEN);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_W-1:0]      r_cnt;
    logic                   r_level;
    logic                   r_qual;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Once the counter has seen FILT_LEN differing samples the level flips even
    // if the input has already returned, so a pulse of exactly FILT_LEN is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_qual  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_qual <= 1'b0;
            if (i_load) begin
                r_level <= w_sync;
                r_cnt   <= '0;
            end else if (i_run) begin
                if (r_cnt == FILT_MAX) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                    r_qual  <= 1'b1;
                end else if (w_sync != r_level) begin
                    r_cnt <= r_cnt + FILT_W'(1);
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign o_sync  = w_sync;
    assign o_level = r_level;
    assign o_qual  = r_qual;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder top: primes from the synchronised phases after reset, then
// turns accepted Gray transitions into step/direction pulses and a sticky error.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave bus
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

    logic              w_syncA, w_syncB;
    logic              w_levelA, w_levelB;
    logic              w_qualA, w_qualB;
    logic              w_load;
    logic              w_change, w_isUp, w_isDown, w_illegal;
    phase_t            w_s;
    logic [FILL_W-1:0] r_fill;
    logic              r_primed;
    phase_t            r_prev;
    logic              r_step;
    logic              r_upDown;
    logic              r_err;

    assign w_load = !r_primed && (r_fill == FILL_DONE);

    sync_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) uFiltA (
        .clk    (clk),
        .rst    (rst),
        .i_in   (bus.i_a_in),
        .i_load (w_load),
        .i_run  (r_primed),
        .o_sync (w_syncA),
        .o_level(w_levelA),
        .o_qual (w_qualA)
    );

    sync_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) uFiltB (
        .clk    (clk),
        .rst    (rst),
        .i_in   (bus.i_b_in),
        .i_load (w_load),
        .i_run  (r_primed),
        .o_sync (w_syncB),
        .o_level(w_levelB),
        .o_qual (w_qualB)
    );

    assign w_s       = phase_t'({w_levelA, w_levelB});
    assign w_change  = r_primed && (w_qualA || w_qualB) && (w_s != r_prev);
    assign w_isUp    = (w_s == next_up(r_prev));
    assign w_isDown  = (r_prev == next_up(w_s));
    assign w_illegal = w_change && !w_isUp && !w_isDown;

    // Previous phase follows the accepted phase every cycle, so an illegal jump
    // resyncs decoding and en=0 leaves nothing to catch up on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill   <= '0;
            r_primed <= 1'b0;
            r_prev   <= PH_00;
            r_step   <= 1'b0;
            r_upDown <= DIR_UP;
            r_err    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (!r_primed) begin
                if (w_load) begin
                    r_primed <= 1'b1;
                    r_prev   <= phase_t'({w_syncA, w_syncB});
                end else begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end else begin
                r_prev <= w_s;
            end
            if (w_change && bus.i_en && (w_isUp || w_isDown)) begin
                r_step   <= 1'b1;
                r_upDown <= w_isUp ? DIR_UP : DIR_DOWN;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (bus.i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.o_step    = r_step;
    assign bus.o_up_down = r_upDown;
    assign bus.o_err     = r_err;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with defaults SYNC_STAGES=2, FILT_LEN=4:
// inputs change on negedge, outputs sampled on negedge, step expected 8 samples later.
module tb_quad_step_decoder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    quad_step_decoder_if bus();

    quad_step_decoder #(
        .SYNC_STAGES(2),
        .FILT_LEN   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the new phase is first sampled at the next posedge,
    // so a registered step from it is seen on the 8th following negedge.
    task automatic applyStimulus(input logic a, input logic b, input int hold,
                                 input logic expStep, input logic expDir, input string tag);
        bus.i_a_in = a;
        bus.i_b_in = b;
        for (int n = 1; n <= hold; n++) begin
            @(negedge clk);
            if (n <= 9) begin
                checkOutput({tag, " step"}, bus.o_step, (n == 8) ? expStep : 1'b0);
                if (n == 8 && expStep)
                    checkOutput({tag, " dir"}, bus.o_up_down, expDir);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b1;
        bus.i_en      = 1'b1;
        bus.i_a_in    = 1'b0;
        bus.i_b_in    = 1'b0;
        bus.i_err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset step", bus.o_step, 1'b0);
        checkOutput("reset dir", bus.o_up_down, 1'b1);
        checkOutput("reset err", bus.o_err, 1'b0);
        rst = 1'b0;

        $display("[TB] T1 idle after reset");
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checkOutput("T1 step", bus.o_step, 1'b0);
        end
        checkOutput("T1 dir", bus.o_up_down, 1'b1);
        checkOutput("T1 err", bus.o_err, 1'b0);

        $display("[TB] T2 up sequence");
        applyStimulus(1'b1, 1'b0, 10, 1'b1, 1'b1, "T2 00->10");
        applyStimulus(1'b1, 1'b1, 10, 1'b1, 1'b1, "T2 10->11");
        applyStimulus(1'b0, 1'b1, 10, 1'b1, 1'b1, "T2 11->01");
        applyStimulus(1'b0, 1'b0, 10, 1'b1, 1'b1, "T2 01->00");
        checkOutput("T2 err", bus.o_err, 1'b0);

        $display("[TB] T3 down sequence");
        applyStimulus(1'b0, 1'b1, 10, 1'b1, 1'b0, "T3 00->01");
        applyStimulus(1'b1, 1'b1, 10, 1'b1, 1'b0, "T3 01->11");
        applyStimulus(1'b1, 1'b0, 10, 1'b1, 1'b0, "T3 11->10");
        applyStimulus(1'b0, 1'b0, 10, 1'b1, 1'b0, "T3 10->00");
        checkOutput("T3 dir held", bus.o_up_down, 1'b0);
        checkOutput("T3 err", bus.o_err, 1'b0);

        $display("[TB] T4 glitch filter");
        bus.i_a_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_a_in = 1'b0;
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            checkOutput("T4 3clk step", bus.o_step, 1'b0);
        end
        checkOutput("T4 3clk err", bus.o_err, 1'b0);
        // A 4-clock pulse qualifies; its return to 0 qualifies FILT_LEN+1 clocks later.
        bus.i_a_in = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            checkOutput("T4 4clk step", bus.o_step, (n == 8) || (n == 13));
            if (n == 8)  checkOutput("T4 4clk dir up", bus.o_up_down, 1'b1);
            if (n == 13) checkOutput("T4 4clk dir down", bus.o_up_down, 1'b0);
            if (n == 4)  bus.i_a_in = 1'b0;
        end
        checkOutput("T4 4clk err", bus.o_err, 1'b0);

        $display("[TB] T5 illegal transitions");
        bus.i_a_in = 1'b1;
        bus.i_b_in = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            checkOutput("T5 00->11 step", bus.o_step, 1'b0);
            if (n == 7) checkOutput("T5 err before latency", bus.o_err, 1'b0);
            if (n == 8) checkOutput("T5 err at latency", bus.o_err, 1'b1);
        end
        bus.i_err_clr = 1'b1;
        @(negedge clk);
        bus.i_err_clr = 1'b0;
        checkOutput("T5 err cleared", bus.o_err, 1'b0);
        bus.i_a_in = 1'b0;
        bus.i_b_in = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            checkOutput("T5 11->00 step", bus.o_step, 1'b0);
            if (n == 7) begin
                checkOutput("T5 err before set", bus.o_err, 1'b0);
                bus.i_err_clr = 1'b1;
            end
            if (n == 8) begin
                checkOutput("T5 set beats clear", bus.o_err, 1'b1);
                bus.i_err_clr = 1'b0;
            end
        end
        checkOutput("T5 err sticky", bus.o_err, 1'b1);
        checkOutput("T5 dir held", bus.o_up_down, 1'b0);

        $display("[TB] T6 enable gating and mid-sequence reset");
        bus.i_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 10, 1'b0, 1'b0, "T6 en0 00->10");
        applyStimulus(1'b1, 1'b1, 10, 1'b0, 1'b0, "T6 en0 10->11");
        checkOutput("T6 en0 dir held", bus.o_up_down, 1'b0);
        bus.i_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checkOutput("T6 no catch-up", bus.o_step, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 10, 1'b1, 1'b1, "T6 11->01");
        bus.i_a_in = 1'b0;
        bus.i_b_in = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("T6 rst step", bus.o_step, 1'b0);
        checkOutput("T6 rst dir", bus.o_up_down, 1'b1);
        checkOutput("T6 rst err", bus.o_err, 1'b0);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checkOutput("T6 reprime step", bus.o_step, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 10, 1'b1, 1'b1, "T6 after reprime 00->10");
        checkOutput("T6 final err", bus.o_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
